// File: rtl/load_store_unit.sv
// Byte/half/word load-store sequencer in front of a one-cycle-latency data memory.
// Latency: error 1, word store 2, load 3, sub-word store 4 cycles; DONE holds until Resp_ready.
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Req_valid,
   output logic              Req_ready,
   input  logic              Req_write,
   input  logic [1:0]        Req_size,
   input  logic              Req_signed,
   input  logic [ADDR_W-1:0] Req_address,
   input  logic [DATA_W-1:0] Req_wdata,
   output logic              Resp_valid,
   input  logic              Resp_ready,
   output logic [DATA_W-1:0] Resp_rdata,
   output logic              Resp_error,
   output logic [ADDR_W-1:0] Data_address,
   output logic [DATA_W-1:0] Data_in,
   output logic              we,
   output logic              re,
   input  logic [DATA_W-1:0] Data_out
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_size;
   logic                r_signed;
   logic                r_write;
   logic [DATA_W-1:0]   r_wbuf;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_error;

   logic                w_accept;
   logic                w_bad;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [DATA_W-1:0]   w_load;
   logic [DATA_W-1:0]   w_merge;

   assign w_accept = Req_valid && (r_state == S_IDLE);
   assign w_bad    = (Req_size == 2'b11) ||
                     ((Req_size == 2'b01) && Req_address[0]) ||
                     ((Req_size == 2'b10) && (Req_address[1:0] != 2'b00));

   assign w_byte = Data_out[{r_addr[1:0], 3'b000} +: 8];
   assign w_half = Data_out[{r_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_load = Data_out;
      case (r_size)
         2'b00:   w_load = {{(DATA_W-8){r_signed & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{(DATA_W-16){r_signed & w_half[15]}}, w_half};
         default: w_load = Data_out;
      endcase
   end

   // Sub-word store: overlay the new lane(s) on the word just read back.
   always_comb begin
      w_merge = Data_out;
      if (r_size == 2'b00)
         w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wbuf[7:0];
      else
         w_merge[{r_addr[1], 4'b0000} +: 16] = r_wbuf[15:0];
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_bad)
                  w_next = S_DONE;
               else if (Req_write && (Req_size == 2'b10))
                  w_next = S_WRITE;
               else
                  w_next = S_READ;
            end
         end
         S_READ:    w_next = S_CAPTURE;
         S_CAPTURE: w_next = r_write ? S_WRITE : S_DONE;
         S_WRITE:   w_next = S_DONE;
         S_DONE:    w_next = Resp_ready ? S_IDLE : S_DONE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_size   <= '0;
         r_signed <= 1'b0;
         r_write  <= 1'b0;
         r_wbuf   <= '0;
         r_rdata  <= '0;
         r_error  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr   <= Req_address;
            r_size   <= Req_size;
            r_signed <= Req_signed;
            r_write  <= Req_write;
            r_wbuf   <= Req_wdata;
            r_rdata  <= '0;
            r_error  <= w_bad;
         end
         if (r_state == S_CAPTURE) begin
            if (r_write)
               r_wbuf <= w_merge;
            else
               r_rdata <= w_load;
         end
      end
   end

   assign Req_ready    = (r_state == S_IDLE);
   assign Resp_valid   = (r_state == S_DONE);
   assign re           = (r_state == S_READ);
   assign we           = (r_state == S_WRITE);
   assign Resp_rdata   = r_rdata;
   assign Resp_error   = r_error;
   assign Data_address = (re || we) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign Data_in      = we ? r_wbuf : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of accesses against a one-cycle registered memory model,
// plus backpressure and mid-access reset sequences.
module tb_load_store_unit;

   logic        Clk, Rst_n;
   logic        Req_valid, Req_ready, Req_write, Req_signed;
   logic [1:0]  Req_size;
   logic [31:0] Req_address, Req_wdata;
   logic        Resp_valid, Resp_ready, Resp_error;
   logic [31:0] Resp_rdata, Data_address, Data_in, Data_out;
   logic        we, re;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_write(Req_write),
      .Req_size(Req_size), .Req_signed(Req_signed), .Req_address(Req_address),
      .Req_wdata(Req_wdata), .Resp_valid(Resp_valid), .Resp_ready(Resp_ready),
      .Resp_rdata(Resp_rdata), .Resp_error(Resp_error), .Data_address(Data_address),
      .Data_in(Data_in), .we(we), .re(re), .Data_out(Data_out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [31:0] mem [0:1023];
   always @(posedge Clk) begin
      if (re) Data_out <= mem[Data_address[11:2]];
      if (we) mem[Data_address[11:2]] <= Data_in;
   end

   int unsigned re_cnt = 0, we_cnt = 0;
   logic [31:0] last_we_dat, last_we_adr, last_re_adr;
   logic        both_seen = 1'b0, busy_in_done = 1'b0;
   always @(negedge Clk) begin
      if (re) begin re_cnt++; last_re_adr = Data_address; end
      if (we) begin we_cnt++; last_we_dat = Data_in; last_we_adr = Data_address; end
      if (we && re) both_seen = 1'b1;
      if (Resp_valid && (we || re)) busy_in_done = 1'b1;
   end

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
      int          lat;
      int          n_re;
      int          n_we;
      logic [31:0] wdat;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          lat;
      int          n_re;
      int          n_we;
      logic [31:0] wdat;
      logic [31:0] wadr;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic issue(input vec_t v, input int idx);
      int n, lat;
      int unsigned re0, we0;
      exp_t e;
      @(negedge Clk);
      Req_write = v.wr; Req_size = v.sz; Req_signed = v.sg;
      Req_address = v.addr; Req_wdata = v.wd; Req_valid = 1'b1;
      n = 0;
      while (!Req_ready && n < 50) begin @(negedge Clk); n++; end
      if (!Req_ready) begin
         chk($sformatf("v%0d_accept_timeout", idx), 32'd0, 32'd1);
         Req_valid = 1'b0;
         return;
      end
      re0 = re_cnt; we0 = we_cnt;
      e.rd = v.rd; e.err = v.err; e.lat = v.lat; e.n_re = v.n_re; e.n_we = v.n_we;
      e.wdat = v.wdat; e.wadr = {v.addr[31:2], 2'b00};
      sb.push_back(e);
      @(posedge Clk); #1;
      Req_valid = 1'b0; Req_address = $urandom; Req_wdata = $urandom;
      Req_size = 2'($urandom_range(0, 3)); Req_write = 1'($urandom); Req_signed = 1'($urandom);
      lat = 0;
      do begin @(negedge Clk); lat++; end while (!Resp_valid && lat < 30);
      e = sb.pop_front();
      if (!Resp_valid) begin
         chk($sformatf("v%0d_resp_timeout", idx), 32'd0, 32'd1);
         return;
      end
      chk($sformatf("v%0d_rdata", idx), Resp_rdata, e.rd);
      chk($sformatf("v%0d_error", idx), 32'(Resp_error), 32'(e.err));
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(e.lat));
      chk($sformatf("v%0d_re_cycles", idx), re_cnt - re0, 32'(e.n_re));
      chk($sformatf("v%0d_we_cycles", idx), we_cnt - we0, 32'(e.n_we));
      if (e.n_re == 1) chk($sformatf("v%0d_re_addr", idx), last_re_adr, e.wadr);
      if (e.n_we == 1) begin
         chk($sformatf("v%0d_we_data", idx), last_we_dat, e.wdat);
         chk($sformatf("v%0d_we_addr", idx), last_we_adr, e.wadr);
      end
   endtask

   vec_t tbl[18];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic ok, seen;
      logic [31:0] held;
      exp_t e;

      //        wr  sz    sg  addr   wdata         rdata         err lat re we wdat
      tbl[0]  = '{1, 2'b10, 0, 1024, 32'hFFFFFFFF, 32'h0,        0, 2, 0, 1, 32'hFFFFFFFF};
      tbl[1]  = '{0, 2'b10, 0, 1024, 32'h0,        32'hFFFFFFFF, 0, 3, 1, 0, 32'h0};
      tbl[2]  = '{1, 2'b10, 0, 1024, 32'h11223344, 32'h0,        0, 2, 0, 1, 32'h11223344};
      tbl[3]  = '{1, 2'b00, 0, 1025, 32'hDEADBEAB, 32'h0,        0, 4, 1, 1, 32'h1122AB44};
      tbl[4]  = '{0, 2'b10, 0, 1024, 32'h0,        32'h1122AB44, 0, 3, 1, 0, 32'h0};
      tbl[5]  = '{0, 2'b00, 1, 1025, 32'h0,        32'hFFFFFFAB, 0, 3, 1, 0, 32'h0};
      tbl[6]  = '{0, 2'b00, 0, 1025, 32'h0,        32'h000000AB, 0, 3, 1, 0, 32'h0};
      tbl[7]  = '{1, 2'b10, 0, 1024, 32'h80011234, 32'h0,        0, 2, 0, 1, 32'h80011234};
      tbl[8]  = '{0, 2'b01, 1, 1026, 32'h0,        32'hFFFF8001, 0, 3, 1, 0, 32'h0};
      tbl[9]  = '{0, 2'b01, 1, 1024, 32'h0,        32'h00001234, 0, 3, 1, 0, 32'h0};
      tbl[10] = '{1, 2'b01, 0, 1026, 32'h5555CAFE, 32'h0,        0, 4, 1, 1, 32'hCAFE1234};
      tbl[11] = '{0, 2'b00, 1, 1027, 32'h0,        32'hFFFFFFCA, 0, 3, 1, 0, 32'h0};
      tbl[12] = '{0, 2'b00, 0, 1024, 32'h0,        32'h00000034, 0, 3, 1, 0, 32'h0};
      tbl[13] = '{0, 2'b01, 1, 1025, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0};
      tbl[14] = '{0, 2'b10, 0, 1026, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0};
      tbl[15] = '{1, 2'b11, 0, 1024, 32'h12345678, 32'h0,        1, 1, 0, 0, 32'h0};
      tbl[16] = '{1, 2'b00, 0, 1024, 32'h12345677, 32'h0,        0, 4, 1, 1, 32'hCAFE1277};
      tbl[17] = '{0, 2'b10, 0, 1024, 32'h0,        32'hCAFE1277, 0, 3, 1, 0, 32'h0};

      Rst_n = 1'b0; Req_valid = 1'b0; Req_write = 1'b0; Req_size = 2'b00; Req_signed = 1'b0;
      Req_address = '0; Req_wdata = '0; Resp_ready = 1'b1;
      #3;
      chk("reset_req_ready", 32'(Req_ready), 32'd1);
      chk("reset_resp_valid_err", {30'd0, Resp_valid, Resp_error}, 32'd0);
      chk("reset_we_re", {30'd0, we, re}, 32'd0);
      chk("reset_data_address", Data_address, 32'd0);
      chk("reset_data_in", Data_in, 32'd0);
      chk("reset_resp_rdata", Resp_rdata, 32'd0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;

      for (int i = 0; i < 18; i++) issue(tbl[i], i);

      // Backpressure: word load held in DONE, a byte load waiting behind it.
      @(negedge Clk);
      Resp_ready = 1'b0;
      chk("bp_idle_ready", 32'(Req_ready), 32'd1);
      Req_write = 1'b0; Req_size = 2'b10; Req_signed = 1'b0; Req_address = 1024; Req_valid = 1'b1;
      e = '{32'hCAFE1277, 1'b0, 3, 1, 0, 32'h0, 32'd1024};
      sb.push_back(e);
      @(posedge Clk); #1;
      Req_size = 2'b00; Req_address = 1027;
      n = 0;
      do begin @(negedge Clk); n++; end while (!Resp_valid && n < 30);
      e = sb.pop_front();
      chk("bp_first_rdata", Resp_rdata, e.rd);
      chk("bp_first_latency", 32'(n), 32'(e.lat));
      held = Resp_rdata;
      ok = 1'b1;
      repeat (5) begin
         @(negedge Clk);
         if (!Resp_valid || Resp_rdata !== held || Req_ready || we || re) ok = 1'b0;
      end
      chk("bp_hold_stable", 32'(ok), 32'd1);
      e = '{32'h000000CA, 1'b0, 4, 1, 0, 32'h0, 32'd1024};
      sb.push_back(e);
      Resp_ready = 1'b1;
      @(negedge Clk);
      n = 1;
      chk("bp_after_handshake_ready", {30'd0, Req_ready, Resp_valid}, 32'd2);
      @(posedge Clk); #1;
      Req_valid = 1'b0;
      do begin @(negedge Clk); n++; end while (!Resp_valid && n < 30);
      e = sb.pop_front();
      chk("bp_second_rdata", Resp_rdata, e.rd);
      chk("bp_second_latency", 32'(n), 32'(e.lat));

      // Reset during READ of a load.
      @(negedge Clk);
      Req_write = 1'b0; Req_size = 2'b10; Req_address = 1024; Req_valid = 1'b1;
      @(posedge Clk); #1;
      Req_valid = 1'b0;
      @(negedge Clk);
      chk("rst_mid_in_read", 32'(re), 32'd1);
      #2 Rst_n = 1'b0;
      #1;
      chk("rst_mid_re_async", 32'(re), 32'd0);
      chk("rst_mid_ready_valid", {30'd0, Req_ready, Resp_valid}, 32'd2);
      chk("rst_mid_data_address", Data_address, 32'd0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin @(negedge Clk); if (Resp_valid) seen = 1'b1; end
      chk("rst_mid_no_response", 32'(seen), 32'd0);
      chk("rst_mid_ready_after", 32'(Req_ready), 32'd1);
      issue(tbl[17], 100);

      chk("never_we_and_re", 32'(both_seen), 32'd0);
      chk("no_mem_access_in_done", 32'(busy_in_done), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
